mult_seq: RTL
=============

# mult_seq

Sequential shift-add multiply-accumulate unit for the arithmetic section of the ALU. It is the parametrised successor of the combinational multiplier. It computes a full-width `out = A*B + C` over WIRE+2 cycles, in unsigned or two's-complement mode, with valid/ready handshakes on both sides. It trades latency for area and serves wide datapaths where a combinational array multiplier is too large.

## Interface
- `WIRE`, default 8: operand width in bits (WIRE >= 2); the product is 2*WIRE bits.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `in_valid` input, 1 bit: operands on A/B/C/sign are valid.
- `in_ready` output, 1 bit: block can accept an operation (IDLE only).
- `A` input, WIRE bits: multiplicand.
- `B` input, WIRE bits: multiplier.
- `C` input, WIRE bits: addend, extended to 2*WIRE bits per mode.
- `sign` input, 1 bit: 0 = unsigned, 1 = two's complement for A, B and C.
- `out_valid` output, 1 bit: `out` holds a finished result.
- `out_ready` input, 1 bit: consumer accepts the result.
- `out` output, 2*WIRE bits: result A*B + C.

## Operation
- Four states: IDLE, RUN, FIN, DONE. Reset enters IDLE; reset is legal in any state.
- IDLE: `in_ready`=1. On `in_valid` & `in_ready`:
  - latch `sign`;
  - latch `|A|` and `|B|` (magnitudes if sign=1, raw values if sign=0);
  - latch the negate flag `A[WIRE-1]^B[WIRE-1]` when sign=1, else 0;
  - latch C extended to 2*WIRE bits (zero-extended if sign=0, sign-extended if sign=1);
  - clear the accumulator and bit counter, then go to RUN.
- RUN: one multiplier bit per cycle, LSB first. If the current bit is 1, add the shifted multiplicand to the 2*WIRE-bit accumulator. The counter advances. After exactly WIRE RUN cycles, go to FIN.
- FIN: one cycle. Two's-complement negate the accumulator if the negate flag is set, add the extended C, register the sum into `out`, then go to DONE.
- DONE: `out_valid`=1. On `out_ready` go to IDLE. `out` keeps its value after the handshake until the next FIN.
- Inputs A/B/C/sign are don't-care outside the accept cycle. Changes during RUN, FIN or DONE have no effect.
- `in_valid` outside IDLE is ignored; the request is not queued.
- Width rules: no overflow is possible in either mode.
  - Unsigned worst case: (2^W-1)^2 + (2^W-1) < 2^2W.
  - Signed worst case: (-2^(W-1))^2 + (2^(W-1)-1) < 2^(2W-1).
  - The magnitude of -2^(W-1) is 2^(W-1) and fits in W unsigned bits; it needs no special case.
- Results are exact modulo nothing: bit-identical to the mathematical A*B+C in 2*WIRE bits.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `out`=0, accumulator and counter 0.
- Asynchronous reset: outputs take reset values immediately on `rst` rising, with no clock needed.
- Accept on edge e0. RUN occupies edges e1..eWIRE. FIN is edge eWIRE+1.
- `out_valid` rises after edge eWIRE+1, i.e. WIRE+2 cycles after the accept edge. For WIRE=8, latency is 10 cycles.
- Result handshake on edge eK with `out_valid` & `out_ready`. `in_ready` is 1 from the cycle after eK. The earliest next accept is edge eK+1.
- Maximum throughput: one operation per WIRE+3 cycles with `out_ready` held high.
- `out_ready` low in DONE: `out` and `out_valid` are held stable indefinitely.
- `in_ready` and `out_valid` are never 1 in the same cycle.
- Reset mid-RUN or mid-FIN: the operation is discarded and no `out_valid` pulse is produced. After reset release, the block is ready in the next cycle.

## Test plan
- Reset, then unsigned A=3, B=5, C=0 -> `out`=15, `out_valid` exactly 10 cycles after accept, `in_ready`=0 throughout.
- Unsigned A=255, B=255, C=255 -> `out`=0xFF00 (65280). Then A=8, B=12, C=0 -> `out`=96, accepted on the cycle after the first result handshake.
- Signed A=-128 (0x80), B=-128, C=0 -> `out`=0x4000. Signed A=-3 (0xFD), B=5, C=-1 (0xFF) -> `out`=0xFFF0 (-16).
- Backpressure: result 3*10=30 with `out_ready` low for 5 cycles -> `out_valid`=1 and `out`=30 held stable, `in_valid` pulses ignored, IDLE entered only after `out_ready`=1.
- `rst` asserted on the 4th RUN cycle of 7*9 -> all outputs 0 immediately, no `out_valid`. A following 2*2+1 gives `out`=5.
- Operand change during RUN: accept A=6, B=7, C=2, then drive random values on A/B/C/sign -> `out`=44.

Source files
------------

// File: rtl/mult_seq.sv
// rtl/mult_seq.sv - sequential shift-add multiply-accumulate, out = A*B + C over WIRE+2 cycles
module mult_seq #(
  parameter int WIRE = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIRE-1:0]     A,
  input  logic [WIRE-1:0]     B,
  input  logic [WIRE-1:0]     C,
  input  logic                sign,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*WIRE-1:0]   out
);

  localparam int PW = 2 * WIRE;
  localparam int CW = $clog2(WIRE);

  typedef enum logic [1:0] {IDLE, RUN, FIN, DONE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [WIRE-1:0] mplier_q, mplier_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   c_q, c_d;
  logic [PW-1:0]   out_q, out_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_q, neg_d;

  // Magnitudes of the operands; -2^(WIRE-1) maps onto itself, read as unsigned.
  logic [WIRE-1:0] a_mag, b_mag;
  assign a_mag = (sign && A[WIRE-1]) ? -A : A;
  assign b_mag = (sign && B[WIRE-1]) ? -B : B;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      c_q      <= '0;
      out_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      c_q      <= c_d;
      out_q    <= out_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    c_d       = c_q;
    out_d     = out_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mcand_d  = {{WIRE{1'b0}}, a_mag};
          mplier_d = b_mag;
          neg_d    = sign & (A[WIRE-1] ^ B[WIRE-1]);
          c_d      = {{WIRE{sign & C[WIRE-1]}}, C};
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        // Multiplicand is pre-shifted each cycle so bit k of B adds A<<k.
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIRE - 1)) state_d = FIN;
      end
      FIN: begin
        out_d   = (neg_q ? -acc_q : acc_q) + c_q;
        state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign out = out_q;

endmodule
